verificacion_pin: RTL and testbench

- Upstream authorization stage of the automatic cashier. Sits between card reader/keypad and the transaction stage.
- Captures the card's stored PIN when a card is detected, then assembles keypad digits into an entered PIN and compares the two.
- Counts failed attempts and raises a warning and a permanent lock.
- Its `pin_ok` level qualifies the transaction stage: `tipo_trans`/`monto` are only acted on while `pin_ok` is high.

---
 rtl/verificacion_pin_if.sv | 39 +++
 rtl/verificacion_pin.sv | 129 ++++++++++++
 tb/tb_verificacion_pin.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/verificacion_pin_if.sv
// Card-reader/keypad side signals of the PIN authorization stage, plus its status outputs.
// The master drives card and keypad inputs; the slave is the authorization block.
interface verificacion_pin_if #(
    parameter int unsigned N_DIGITOS = 4
) ();
    logic                     tarjeta_recibida;
    logic [4*N_DIGITOS-1:0]   pin_correcto;
    logic [3:0]               digito;
    logic                     digito_stb;
    logic                     pin_ok;
    logic                     pin_incorrecto;
    logic                     advertencia;
    logic                     bloqueo;
    logic [1:0]               intentos;

    modport master (
        output tarjeta_recibida,
        output pin_correcto,
        output digito,
        output digito_stb,
        input  pin_ok,
        input  pin_incorrecto,
        input  advertencia,
        input  bloqueo,
        input  intentos
    );

    modport slave (
        input  tarjeta_recibida,
        input  pin_correcto,
        input  digito,
        input  digito_stb,
        output pin_ok,
        output pin_incorrecto,
        output advertencia,
        output bloqueo,
        output intentos
    );
endinterface

// File: rtl/verificacion_pin.sv
// PIN authorization: captures the card PIN, assembles keypad BCD digits, compares them,
// and tracks failed attempts up to a sticky lock. pin_ok qualifies the transaction stage.
module verificacion_pin #(
    parameter int unsigned N_DIGITOS    = 4,
    parameter int unsigned MAX_INTENTOS = 3
) (
    input  logic               clk,
    input  logic               reset,
    verificacion_pin_if.slave  bus
);

    localparam int unsigned PinW = 4 * N_DIGITOS;
    localparam int unsigned CntW = $clog2(N_DIGITOS + 1);

    typedef enum logic [2:0] {
        StEspera,
        StRecibirPin,
        StVerificar,
        StAutorizado,
        StBloqueado
    } estado_e;

    estado_e             state_q, state_d;
    logic [PinW-1:0]     pin_cap_q, pin_cap_d;
    logic [PinW-1:0]     pin_ent_q, pin_ent_d;
    logic [CntW-1:0]     cuenta_q, cuenta_d;
    logic [1:0]          intentos_q, intentos_d;
    logic                pin_incorrecto_q, pin_incorrecto_d;
    logic                digito_valido;

    // Non-BCD keys are dropped without touching the digit count.
    assign digito_valido = bus.digito_stb && (bus.digito <= 4'd9);

    always_comb begin
        state_d          = state_q;
        pin_cap_d        = pin_cap_q;
        pin_ent_d        = pin_ent_q;
        cuenta_d         = cuenta_q;
        intentos_d       = intentos_q;
        pin_incorrecto_d = 1'b0;

        unique case (state_q)
            StEspera: begin
                if (bus.tarjeta_recibida) begin
                    pin_cap_d = bus.pin_correcto;
                    pin_ent_d = '0;
                    cuenta_d  = '0;
                    state_d   = StRecibirPin;
                end
            end

            StRecibirPin: begin
                // Removal wins over a simultaneous final strobe.
                if (!bus.tarjeta_recibida) begin
                    pin_ent_d = '0;
                    cuenta_d  = '0;
                    state_d   = StEspera;
                end else if (digito_valido) begin
                    pin_ent_d = {pin_ent_q[PinW-5:0], bus.digito};
                    cuenta_d  = cuenta_q + CntW'(1);
                    if (cuenta_q == CntW'(N_DIGITOS - 1)) begin
                        state_d = StVerificar;
                    end
                end
            end

            StVerificar: begin
                if (!bus.tarjeta_recibida) begin
                    pin_ent_d = '0;
                    cuenta_d  = '0;
                    state_d   = StEspera;
                end else if (pin_ent_q == pin_cap_q) begin
                    intentos_d = 2'd0;
                    state_d    = StAutorizado;
                end else begin
                    intentos_d       = intentos_q + 2'd1;
                    pin_incorrecto_d = 1'b1;
                    if (intentos_d == 2'(MAX_INTENTOS)) begin
                        state_d = StBloqueado;
                    end else begin
                        pin_ent_d = '0;
                        cuenta_d  = '0;
                        state_d   = StRecibirPin;
                    end
                end
            end

            StAutorizado: begin
                if (!bus.tarjeta_recibida) begin
                    state_d = StEspera;
                end
            end

            // Only reset leaves the lock.
            StBloqueado: begin
                state_d = StBloqueado;
            end

            default: begin
                state_d = StEspera;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StEspera;
            pin_cap_q        <= '0;
            pin_ent_q        <= '0;
            cuenta_q         <= '0;
            intentos_q       <= 2'd0;
            pin_incorrecto_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            pin_cap_q        <= pin_cap_d;
            pin_ent_q        <= pin_ent_d;
            cuenta_q         <= cuenta_d;
            intentos_q       <= intentos_d;
            pin_incorrecto_q <= pin_incorrecto_d;
        end
    end

    assign bus.pin_ok         = (state_q == StAutorizado);
    assign bus.bloqueo        = (state_q == StBloqueado);
    assign bus.pin_incorrecto = pin_incorrecto_q;
    assign bus.intentos       = intentos_q;
    assign bus.advertencia    = (intentos_q == 2'(MAX_INTENTOS - 1));

endmodule

// File: tb/tb_verificacion_pin.sv
// Directed bench for verificacion_pin: hand-computed expectations for authorization,
// wrong attempts, lock, invalid keys, card removal and asynchronous reset.
module tb_verificacion_pin;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    verificacion_pin_if #(.N_DIGITOS(4)) bus ();

    verificacion_pin #(
        .N_DIGITOS    (4),
        .MAX_INTENTOS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insertar(input logic [15:0] pin);
        bus.pin_correcto     = pin;
        bus.tarjeta_recibida = 1'b1;
        tick();
    endtask

    task automatic retirar();
        bus.tarjeta_recibida = 1'b0;
        tick();
    endtask

    task automatic pulsar(input logic [3:0] d);
        bus.digito     = d;
        bus.digito_stb = 1'b1;
        tick();
        bus.digito_stb = 1'b0;
    endtask

    task automatic teclear(input logic [15:0] pin);
        for (int i = 3; i >= 0; i--) begin
            pulsar(pin[4*i +: 4]);
        end
    endtask

    task automatic salidas_cero(input string tag);
        check({tag, ".pin_ok"},         32'(bus.pin_ok), 0);
        check({tag, ".pin_incorrecto"}, 32'(bus.pin_incorrecto), 0);
        check({tag, ".advertencia"},    32'(bus.advertencia), 0);
        check({tag, ".bloqueo"},        32'(bus.bloqueo), 0);
        check({tag, ".intentos"},       32'(bus.intentos), 0);
    endtask

    task automatic aplicar_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        errors               = 0;
        checks               = 0;
        reset                = 1'b0;
        bus.tarjeta_recibida = 1'b0;
        bus.pin_correcto     = '0;
        bus.digito           = '0;
        bus.digito_stb       = 1'b0;
        #2;
        salidas_cero("reset");
        tick();
        reset = 1'b1;
        tick();

        // Correct PIN: pin_ok one edge after the VERIFICAR cycle.
        insertar(16'h1234);
        teclear(16'h1234);
        check("ok.verificar_pin_ok", 32'(bus.pin_ok), 0);
        tick();
        check("ok.pin_ok",         32'(bus.pin_ok), 1);
        check("ok.pin_incorrecto", 32'(bus.pin_incorrecto), 0);
        check("ok.intentos",       32'(bus.intentos), 0);
        bus.tarjeta_recibida = 1'b0;
        #1;
        check("ok.pin_ok_before_edge", 32'(bus.pin_ok), 1);
        tick();
        check("ok.pin_ok_removed", 32'(bus.pin_ok), 0);

        // Wrong then correct.
        insertar(16'h1234);
        teclear(16'h1235);
        tick();
        check("wrong.pin_incorrecto", 32'(bus.pin_incorrecto), 1);
        check("wrong.intentos",       32'(bus.intentos), 1);
        check("wrong.advertencia",    32'(bus.advertencia), 0);
        check("wrong.pin_ok",         32'(bus.pin_ok), 0);
        pulsar(4'h1);
        check("wrong.pulse_width", 32'(bus.pin_incorrecto), 0);
        pulsar(4'h2);
        pulsar(4'h3);
        pulsar(4'h4);
        tick();
        check("retry.pin_ok",   32'(bus.pin_ok), 1);
        check("retry.intentos", 32'(bus.intentos), 0);
        retirar();

        // Invalid keys A and F dropped.
        insertar(16'h1234);
        pulsar(4'h1);
        pulsar(4'hA);
        pulsar(4'h2);
        pulsar(4'hF);
        pulsar(4'h3);
        pulsar(4'h4);
        tick();
        check("bcd.pin_ok", 32'(bus.pin_ok), 1);
        retirar();

        // Removal on the same edge as the last strobe: no compare.
        insertar(16'h1234);
        pulsar(4'h1);
        pulsar(4'h2);
        pulsar(4'h3);
        bus.tarjeta_recibida = 1'b0;
        pulsar(4'h4);
        tick();
        check("race.pin_ok",         32'(bus.pin_ok), 0);
        check("race.pin_incorrecto", 32'(bus.pin_incorrecto), 0);

        // One wrong attempt, then abandon a partial entry: count survives.
        insertar(16'h1234);
        teclear(16'h9999);
        tick();
        check("partial.intentos_1", 32'(bus.intentos), 1);
        pulsar(4'h1);
        pulsar(4'h2);
        retirar();
        tick();
        check("partial.pin_incorrecto", 32'(bus.pin_incorrecto), 0);
        check("partial.intentos",       32'(bus.intentos), 1);

        // Second wrong attempt after reinsertion raises the warning.
        insertar(16'h1234);
        teclear(16'h0000);
        tick();
        check("warn.intentos",    32'(bus.intentos), 2);
        check("warn.advertencia", 32'(bus.advertencia), 1);
        retirar();

        // Third wrong attempt after another reinsertion locks.
        insertar(16'h1234);
        teclear(16'h0000);
        tick();
        check("lock.bloqueo",        32'(bus.bloqueo), 1);
        check("lock.pin_incorrecto", 32'(bus.pin_incorrecto), 1);
        check("lock.pin_ok",         32'(bus.pin_ok), 0);
        teclear(16'h1234);
        retirar();
        insertar(16'h1234);
        teclear(16'h1234);
        tick();
        check("lock.sticky_bloqueo", 32'(bus.bloqueo), 1);
        check("lock.sticky_pin_ok",  32'(bus.pin_ok), 0);
        check("lock.sticky_pulse",   32'(bus.pin_incorrecto), 0);
        #2;
        reset = 1'b0;
        #1;
        salidas_cero("lock_reset");
        tick();
        reset = 1'b1;
        retirar();

        // Lock from three consecutive wrong PINs in one session.
        insertar(16'h1234);
        teclear(16'h0000);
        tick();
        check("lock3.intentos_1", 32'(bus.intentos), 1);
        teclear(16'h0000);
        tick();
        check("lock3.advertencia", 32'(bus.advertencia), 1);
        teclear(16'h0000);
        tick();
        check("lock3.bloqueo", 32'(bus.bloqueo), 1);
        retirar();
        aplicar_reset();

        // Asynchronous reset between edges while authorized.
        insertar(16'h4321);
        teclear(16'h4321);
        tick();
        check("async.pin_ok_before", 32'(bus.pin_ok), 1);
        #2;
        reset = 1'b0;
        #1;
        salidas_cero("async");
        tick();
        reset = 1'b1;
        tick();
        check("async.still_idle", 32'(bus.pin_ok), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
